// File: rtl/lc3b_fetch_unit.sv
// lc3b_fetch_unit: LC-3b instruction fetch stage (PC owner, memory read handshake, valid/ready hand-off to the IR).
// Ports: clk, reset_n (async active-low); redirect/redirect_pc (new PC, squashes current fetch);
//        mem_read/mem_address -> memory, mem_resp/mem_rdata <- memory (resp is a one-cycle pulse);
//        ir_valid/ir_data/ir_pc_next -> IR stage, ir_ready <- IR stage; misalign (sticky odd-target flag).
// Optional: define FETCH_ALIGN_CHECK_EN to force redirect targets even and flag odd ones on misalign.
module lc3b_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        mem_read,
  output logic [15:0] mem_address,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] ir_data,
  output logic [15:0] ir_pc_next,
  output logic        misalign
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  logic [1:0]  state;
  logic [15:0] pc, fetch_addr, pending_pc, tgt, nxt;
`ifdef FETCH_ALIGN_CHECK_EN
  logic mis;
  assign tgt = {redirect_pc[15:1], 1'b0};
  assign misalign = mis;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) mis <= 1'b0;
    else if (redirect && redirect_pc[0]) mis <= 1'b1;
`else
  assign tgt = redirect_pc;
  assign misalign = 1'b0;
`endif
  assign nxt         = fetch_addr + PC_INC;
  assign mem_read    = (state == S_REQ) || (state == S_DRAIN);
  assign mem_address = fetch_addr;
  assign ir_valid    = (state == S_HOLD) && !redirect;
  // A started memory read always runs to its response; a redirect mid-read
  // parks the target in pending_pc (S_DRAIN) until the stale data arrives.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      pending_pc <= RESET_PC;
      ir_data    <= '0;
      ir_pc_next <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (redirect) pc <= tgt;
          else begin
            fetch_addr <= pc;
            state      <= S_REQ;
          end
        S_REQ:
          if (mem_resp && !redirect) begin
            ir_data    <= mem_rdata;
            ir_pc_next <= nxt;
            pc         <= nxt;
            state      <= S_HOLD;
          end else if (mem_resp) begin
            pc    <= tgt;
            state <= S_IDLE;
          end else if (redirect) begin
            pending_pc <= tgt;
            state      <= S_DRAIN;
          end
        S_DRAIN:
          if (mem_resp) begin
            pc    <= redirect ? tgt : pending_pc;
            state <= S_IDLE;
          end else if (redirect) pending_pc <= tgt;
        S_HOLD:
          if (redirect) begin
            pc    <= tgt;
            state <= S_IDLE;
          end else if (ir_ready) state <= S_IDLE;
      endcase
    end
endmodule
